// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner_if
//  Description : Key-code stream between the keypad scanner (master) and its
//                consumer (slave). The head of the key FIFO is presented with
//                a valid/ready handshake, along with the current occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if #(
    parameter int CODEW = 4,
    parameter int CNTW  = 3
);
    logic [CODEW-1:0] key_code;
    logic             key_valid;
    logic             key_ready;
    logic [CNTW-1:0]  fifo_count;

    modport master (
        output key_code,
        output key_valid,
        output fifo_count,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  fifo_count,
        output key_ready
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : Matrix keypad scanner. Walks a one-cold column drive, samples
//                active-low rows, debounces press and release, rejects
//                multi-key chords, optionally auto-repeats a held key, and
//                queues key codes in a first-word-fall-through FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int NROWS      = 4,
    parameter int NCOLS      = 4,
    parameter int DEBOUNCE   = 3,
    parameter int REPEAT     = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int CODEW      = $clog2(NROWS*NCOLS)
) (
    input  wire logic             slowclk,
    input  wire logic             reset,
    input  wire logic [NROWS-1:0] rows,
    output logic      [NCOLS-1:0] cols,
    output logic                  multi_key,
    output logic                  overflow,
    keypad_scanner_if.master      key_if
);

    localparam int COLW = $clog2(NCOLS);
    localparam int ROWW = $clog2(NROWS);
    localparam int DBW  = $clog2(DEBOUNCE + 1);
    localparam int RPTW = (REPEAT > 0) ? $clog2(REPEAT + 1) : 1;
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Scanner state
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [COLW-1:0]   col_q, col_d;
    logic [DBW-1:0]    cnt_q, cnt_d;
    logic [RPTW-1:0]   rpt_q, rpt_d;
    logic [NROWS-1:0]  pat_q, pat_d;
    logic [CODEW-1:0]  code_q, code_d;
    logic              multi_key_q, multi_key_d;
    logic              push;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [CODEW-1:0]  mem_q [FIFO_DEPTH];
    logic [PTRW-1:0]   wr_q, rd_q;
    logic [CNTW-1:0]   count_q;
    logic              overflow_q;

    // Row decode helpers
    logic [NROWS-1:0]  rows_low;
    logic              any_low;
    logic              one_low;
    logic [ROWW-1:0]   row_idx;
    logic [CODEW-1:0]  new_code;
    logic [COLW-1:0]   col_next;
    logic [DBW-1:0]    cnt_inc;
    logic [RPTW-1:0]   rpt_inc;

    // Classify the sampled rows: any key, exactly one key, and which row
    always_comb begin
        rows_low = ~rows;
        any_low  = |rows_low;
        one_low  = any_low && ((rows_low & (rows_low - NROWS'(1))) == '0);
        row_idx  = '0;
        for (int i = 0; i < NROWS; i++) begin
            if (rows_low[i]) begin
                row_idx = ROWW'(i);
            end
        end
        new_code = CODEW'(col_q) * CODEW'(NROWS) + CODEW'(row_idx);
        col_next = (col_q == COLW'(NCOLS - 1)) ? '0 : col_q + COLW'(1);
        cnt_inc  = cnt_q + DBW'(1);
        rpt_inc  = rpt_q + RPTW'(1);
    end

    // Scanner next-state: column walk, debounce, hold/repeat and release
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        rpt_d       = rpt_q;
        pat_d       = pat_q;
        code_d      = code_q;
        multi_key_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            S_SCAN: begin
                if (!any_low) begin
                    col_d = col_next;
                end else if (one_low) begin
                    pat_d   = rows;
                    code_d  = new_code;
                    cnt_d   = DBW'(1);
                    state_d = S_DEBOUNCE;
                end else begin
                    multi_key_d = 1'b1;
                    col_d       = col_next;
                end
            end
            S_DEBOUNCE: begin
                if (rows == pat_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DBW'(DEBOUNCE)) begin
                        push    = 1'b1;
                        rpt_d   = '0;
                        state_d = S_HELD;
                    end
                end else begin
                    state_d = S_SCAN;
                    col_d   = col_next;
                end
            end
            S_HELD: begin
                if (any_low) begin
                    if (REPEAT > 0) begin
                        if (rpt_inc == RPTW'(REPEAT)) begin
                            push  = 1'b1;
                            rpt_d = '0;
                        end else begin
                            rpt_d = rpt_inc;
                        end
                    end
                end else begin
                    cnt_d   = DBW'(1);
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // A low sample here is contact bounce: go back to holding
                // without pushing again; the repeat phase is preserved.
                if (!any_low) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DBW'(DEBOUNCE)) begin
                        state_d = S_SCAN;
                        col_d   = col_next;
                    end
                end else begin
                    state_d = S_HELD;
                end
            end
            default: begin
                state_d = S_SCAN;
            end
        endcase
    end

    // Scanner state registers
    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            state_q     <= S_SCAN;
            col_q       <= '0;
            cnt_q       <= '0;
            rpt_q       <= '0;
            pat_q       <= '1;
            code_q      <= '0;
            multi_key_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            rpt_q       <= rpt_d;
            pat_q       <= pat_d;
            code_q      <= code_d;
            multi_key_q <= multi_key_d;
        end
    end

    // FIFO handshake decode; a pop frees a slot for a same-cycle push
    logic pop;
    logic full;
    logic push_ok;

    always_comb begin
        pop     = (count_q != '0) && key_if.key_ready;
        full    = (count_q == CNTW'(FIFO_DEPTH));
        push_ok = push && (!full || pop);
    end

    // FIFO storage, pointers, occupancy and sticky overflow flag
    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= code_q;
                wr_q        <= wr_q + PTRW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PTRW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign cols              = ~(NCOLS'(1) << col_q);
    assign multi_key         = multi_key_q;
    assign overflow          = overflow_q;
    assign key_if.key_code   = mem_q[rd_q];
    assign key_if.key_valid  = (count_q != '0);
    assign key_if.fifo_count = count_q;

endmodule
`default_nettype wire
